level_sequencer: RTL
====================

// Module: level_sequencer
// PURPOSE
//  Top-level game controller for the SymCounter datapath. Sequences one level as:
//  show target -> player counts -> judge -> advance or end.
//  Latches the target from the pattern source and the player's count from the counter.
//  Computes |count - target|, applies the pass tolerance and drives the level/lose/win
//  status to the display and LED logic.
// PARAMETERS
//  SHOW_CYCLES   100_000_000   cycles target is displayed per level (1 s @ 100 MHz)
//  PLAY_TIMEOUT  1_000_000_000 max cycles in PLAY before forced fail (10 s)
//  MAX_LEVEL     15            level at which a pass ends the game with win
//  TOLERANCE     2             max |count-target| that still passes
//  LEVEL_W       4             level register width (holds MAX_LEVEL)
//  COUNT_W       5             target/count/difference width
// PORTS
//  Clk100M        in   1        system clock, 100 MHz
//  Reset_n        in   1        synchronous active-low reset
//  start          in   1        1-cycle pulse; begins/restarts game (IDLE, OVER, WIN only)
//  target         in   COUNT_W  target value from pattern source; sampled on SHOW entry
//  userCount      in   COUNT_W  player count; sampled on userDone or timeout
//  userDone       in   1        1-cycle pulse; player finished counting
//  level          out  LEVEL_W  current level, 1-based (0 in IDLE)
//  targetOut      out  COUNT_W  latched target for display
//  showTarget     out  1        high throughout SHOW
//  playEnable     out  1        high throughout PLAY; counter accepts input only then
//  levelComplete  out  1        1-cycle pulse in JUDGE
//  difference     out  COUNT_W  registered |userCount-target|, valid from JUDGE until next SHOW
//  incLevel       out  1        1-cycle pulse in PASS
//  lose           out  1        held high in OVER
//  win            out  1        held high in WIN
// BEHAVIOUR
//  - All outputs registered (Moore). Reset_n=0 at an edge -> state IDLE, all outputs 0,
//    timer 0. Applies from any state, mid-level included.
//  - States:
//    - IDLE: start -> SHOW, level<=1.
//    - SHOW: runs exactly SHOW_CYCLES cycles (timer 0..SHOW_CYCLES-1), then PLAY; timer cleared.
//    - PLAY: userDone -> JUDGE, userCount latched. If no userDone by the PLAY_TIMEOUT-th cycle
//      -> JUDGE with timedOut=1.
//    - JUDGE: single cycle. timedOut or difference>TOLERANCE -> OVER. Otherwise
//      level==MAX_LEVEL -> WIN, else PASS.
//    - PASS: single cycle; level<=level+1 -> SHOW.
//    - OVER, WIN: hold status. start -> SHOW, level<=1, lose/win cleared.
//  - target latched into targetOut on every transition into SHOW. Input changes during
//    SHOW/PLAY are ignored.
//  - difference: unsigned, no wrap. Computed as (a>=b) ? a-b : b-a in COUNT_W bits.
//    Boundary: difference==TOLERANCE passes, TOLERANCE+1 fails.
//  - userDone and timeout in the same cycle: userDone wins; count judged normally.
//  - userDone outside PLAY is ignored. start outside IDLE/OVER/WIN is ignored.
//  - Latency:
//    - start@n -> showTarget=1 @n+1.
//    - last SHOW cycle@m -> playEnable=1 @m+1.
//    - userDone@k -> levelComplete=1 @k+1; incLevel or lose/win @k+2; next showTarget @k+3 on pass.
//  - timedOut cleared on SHOW entry. Timer width = clog2(max(SHOW_CYCLES,PLAY_TIMEOUT)).
// TESTING  (SHOW_CYCLES=4, PLAY_TIMEOUT=8, MAX_LEVEL=3, TOLERANCE=2)
//  1. Reset, start@0, target=10 -> showTarget 1..4, playEnable from 5, level=1, targetOut=10.
//  2. PLAY, userCount=12, userDone -> levelComplete 1 cycle, difference=2, incLevel pulse,
//     level=2, showTarget next cycle.
//  3. target=10, userCount=7 (diff 3) -> difference=3, lose=1 held, level stays 1, start ignored
//     until OVER; start -> SHOW, lose=0, level=1.
//  4. No userDone for 8 PLAY cycles -> JUDGE, lose=1. Then repeat with userDone on 8th cycle,
//     diff 0 -> pass.
//  5. Pass levels 1,2,3 -> after level 3 judge, win=1, no incLevel. Mid-SHOW Reset_n=0 -> all
//     outputs 0 next edge.
//  6. target=3, userCount=0 and target=0, userCount=3 -> difference=3 both (no wrap).
//     userDone pulsed in SHOW -> ignored.

Source files
------------

// File: rtl/level_sequencer_if.sv
// Signal bundle between the SymCounter game controller and its pattern source,
// counter and display/LED logic.
interface level_sequencer_if #(
  parameter int COUNT_W = 5,
  parameter int LEVEL_W = 4
);
  // start and userDone are single-cycle request pulses with no ready/backpressure:
  // the controller acts on a pulse only in the states that accept it and drops it otherwise.
  logic               start;
  logic [COUNT_W-1:0] target;
  logic [COUNT_W-1:0] userCount;
  logic               userDone;
  logic [LEVEL_W-1:0] level;
  logic [COUNT_W-1:0] targetOut;
  logic               showTarget;
  logic               playEnable;
  logic               levelComplete;
  logic [COUNT_W-1:0] difference;
  logic               incLevel;
  logic               lose;
  logic               win;
  logic [2:0]         state_dbg;

  modport master (
    output start, target, userCount, userDone,
    input  level, targetOut, showTarget, playEnable, levelComplete,
           difference, incLevel, lose, win, state_dbg
  );

  modport slave (
    input  start, target, userCount, userDone,
    output level, targetOut, showTarget, playEnable, levelComplete,
           difference, incLevel, lose, win, state_dbg
  );
endinterface

// File: rtl/level_sequencer.sv
// SymCounter game controller: show target, let the player count, judge |count-target|,
// then advance a level, lose, or win. All status outputs are registered from the next state.
module level_sequencer #(
  parameter int SHOW_CYCLES  = 100_000_000,
  parameter int PLAY_TIMEOUT = 1_000_000_000,
  parameter int MAX_LEVEL    = 15,
  parameter int TOLERANCE    = 2,
  parameter int LEVEL_W      = 4,
  parameter int COUNT_W      = 5
) (
  input logic               Clk100M,
  input logic               Reset_n,
  level_sequencer_if.slave  bus
);
  localparam int TIMER_MAX = (SHOW_CYCLES > PLAY_TIMEOUT) ? SHOW_CYCLES : PLAY_TIMEOUT;
  localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
  localparam logic [TIMER_W-1:0] SHOW_LAST = TIMER_W'(SHOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PLAY_LAST = TIMER_W'(PLAY_TIMEOUT - 1);
  localparam logic [COUNT_W-1:0] TOL       = COUNT_W'(TOLERANCE);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW, S_PLAY, S_JUDGE, S_PASS, S_OVER, S_WIN
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic               timed_out_q;
  logic               timeout_hit;
  logic               show_entry;
  logic               judge_entry;
  logic [COUNT_W-1:0] abs_diff;
  logic [LEVEL_W-1:0] level_q;
  logic [COUNT_W-1:0] target_q;
  logic [COUNT_W-1:0] diff_q;
  logic               show_q, play_q, judge_q, pass_q, over_q, win_q;

  always_ff @(posedge Clk100M) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // userDone is checked before the timeout so a pulse on the last PLAY cycle is judged normally.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE, S_OVER, S_WIN: if (bus.start) state_d = S_SHOW;
      S_SHOW: if (timer_q == SHOW_LAST) state_d = S_PLAY;
      S_PLAY: begin
        if (bus.userDone) begin
          state_d = S_JUDGE;
        end else if (timer_q == PLAY_LAST) begin
          state_d     = S_JUDGE;
          timeout_hit = 1'b1;
        end
      end
      S_JUDGE: begin
        if (timed_out_q || (diff_q > TOL)) state_d = S_OVER;
        else if (level_q == LEVEL_TOP)     state_d = S_WIN;
        else                               state_d = S_PASS;
      end
      S_PASS:  state_d = S_SHOW;
      default: state_d = S_IDLE;
    endcase
  end

  assign show_entry  = (state_d == S_SHOW) && (state_q != S_SHOW);
  assign judge_entry = (state_q == S_PLAY) && (state_d == S_JUDGE);
  assign abs_diff    = (bus.userCount >= target_q) ? (bus.userCount - target_q)
                                                   : (target_q - bus.userCount);

  // Timer restarts on every state change, so SHOW and PLAY each count from zero.
  always_ff @(posedge Clk100M) begin
    if (!Reset_n || (state_d != state_q))              timer_q <= '0;
    else if ((state_q == S_SHOW) || (state_q == S_PLAY)) timer_q <= timer_q + 1'b1;
    else                                               timer_q <= '0;
  end

  always_ff @(posedge Clk100M) begin
    if (!Reset_n) begin
      level_q     <= '0;
      target_q    <= '0;
      diff_q      <= '0;
      timed_out_q <= 1'b0;
      show_q      <= 1'b0;
      play_q      <= 1'b0;
      judge_q     <= 1'b0;
      pass_q      <= 1'b0;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      show_q  <= (state_d == S_SHOW);
      play_q  <= (state_d == S_PLAY);
      judge_q <= (state_d == S_JUDGE);
      pass_q  <= (state_d == S_PASS);
      over_q  <= (state_d == S_OVER);
      win_q   <= (state_d == S_WIN);
      if (show_entry) begin
        target_q    <= bus.target;
        timed_out_q <= 1'b0;
      end
      if (state_q == S_PASS)  level_q <= level_q + 1'b1;
      else if (show_entry)    level_q <= LEVEL_W'(1);
      if (judge_entry) begin
        diff_q      <= abs_diff;
        timed_out_q <= timeout_hit;
      end
    end
  end

  assign bus.level         = level_q;
  assign bus.targetOut     = target_q;
  assign bus.showTarget    = show_q;
  assign bus.playEnable    = play_q;
  assign bus.levelComplete = judge_q;
  assign bus.difference    = diff_q;
  assign bus.incLevel      = pass_q;
  assign bus.lose          = over_q;
  assign bus.win           = win_q;
  assign bus.state_dbg     = state_q;
endmodule
